// File: rtl/mem_port_arbiter.sv
// Serialises fetch (I), load/store (D) and loader (L) accesses onto one single-port memory.
// Loader wins outright, I/D alternate; ack comes MEM_LAT+2 cycles after the grant, req is held until ack.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 64,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_we,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ack,
  output logic          m_en,
  output logic [1:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    owner,
  output logic [31:0]   txn_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_L    = 2'd3;
  localparam logic [3:0] LAT      = 4'(MEM_LAT);

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [31:0]   txn_q, txn_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 2'b00;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      txn_q     <= txn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    txn_d     = txn_q;
    unique case (state_q)
      IDLE: begin
        if (l_req) begin
          owner_d = OWN_L;
          addr_d  = l_addr;
          wdata_d = DW'(l_wdata);
          we_d    = 2'b01;
          state_d = ISSUE;
        end else if (i_req && !(d_req && rr_q)) begin
          // rr_q only matters when I and D collide
          owner_d = OWN_I;
          addr_d  = i_addr;
          we_d    = 2'b00;
          state_d = ISSUE;
        end else if (d_req) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          if (owner_q == OWN_I) i_rdata_d = (we_q == 2'b00) ? m_rdata : '0;
          if (owner_q == OWN_D) d_rdata_d = (we_q == 2'b00) ? m_rdata : '0;
          state_d = RESP;
        end
      end
      RESP: begin
        txn_d = txn_q + 32'd1;
        if (owner_q == OWN_I) rr_d = 1'b1;
        if (owner_q == OWN_D) rr_d = 1'b0;
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_en    = (state_q == ISSUE);
  assign m_we    = (state_q == ISSUE) ? we_q : 2'b00;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign l_ack   = (state_q == RESP) && (owner_q == OWN_L);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign owner   = owner_q;
  assign txn_cnt = txn_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int L  = 1;
  localparam int L4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset4;
  logic        i_req, d_req, l_req;
  logic [7:0]  i_addr, d_addr, l_addr;
  logic [63:0] d_wdata;
  logic [1:0]  d_we;
  logic [31:0] l_wdata;
  logic [63:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic        i_ack, d_ack, l_ack, m_en;
  logic [1:0]  m_we, owner;
  logic [7:0]  m_addr;
  logic [31:0] txn_cnt;

  logic        d4_req;
  logic [7:0]  d4_addr, m4_addr;
  logic [63:0] d4_rdata, i4_rdata, m4_wdata, m4_rdata;
  logic        d4_ack, i4_ack, l4_ack, m4_en;
  logic [1:0]  m4_we, owner4;
  logic [31:0] txn4;

  mem_port_arbiter #(.AW(8), .DW(64), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_rdata(d_rdata), .d_ack(d_ack),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .owner(owner), .txn_cnt(txn_cnt)
  );

  mem_port_arbiter #(.AW(8), .DW(64), .MEM_LAT(L4)) dut4 (
    .clk(clk), .reset(reset4),
    .i_req(1'b0), .i_addr(8'h00), .i_rdata(i4_rdata), .i_ack(i4_ack),
    .d_req(d4_req), .d_addr(d4_addr), .d_wdata(64'h0), .d_we(2'b00), .d_rdata(d4_rdata), .d_ack(d4_ack),
    .l_req(1'b0), .l_addr(8'h00), .l_wdata(32'h0), .l_ack(l4_ack),
    .m_en(m4_en), .m_we(m4_we), .m_addr(m4_addr), .m_wdata(m4_wdata), .m_rdata(m4_rdata),
    .owner(owner4), .txn_cnt(txn4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: one transaction at a time, k = cycles since the grant cycle.
  logic        busy = 1'b0;
  int          k = 0;
  logic [1:0]  cur_own = 2'd0;
  logic [7:0]  cur_addr = 8'h0;
  logic [63:0] cur_wdata = 64'h0;
  logic [1:0]  cur_we = 2'd0;
  logic        rr = 1'b0;
  logic [63:0] mdl_mem [256];
  logic [63:0] dev_mem [256];
  logic        exp_m_en = 1'b0, exp_i_ack = 1'b0, exp_d_ack = 1'b0, exp_l_ack = 1'b0;
  logic        ackp_i, ackp_d, ackp_l;
  logic [1:0]  exp_owner = 2'd0;
  logic [31:0] exp_txn = 32'd0;
  logic [63:0] exp_i_rd = 64'h0, exp_d_rd = 64'h0;
  int          cyc = 0;
  int          due = -1;
  logic [7:0]  due_addr = 8'h0;
  logic        chk_en = 1'b0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [1:0] we);
    return (we == 2'b01) ? {old[63:32], wd[31:0]} : wd;
  endfunction

  task automatic tick();
    if (!busy && (l_req || i_req || d_req)) begin
      if (l_req) begin
        cur_own = 2'd3; cur_addr = l_addr; cur_wdata = {32'h0, l_wdata}; cur_we = 2'b01;
      end else if (i_req && !(d_req && rr)) begin
        cur_own = 2'd1; cur_addr = i_addr; cur_we = 2'b00;
      end else begin
        cur_own = 2'd2; cur_addr = d_addr; cur_wdata = d_wdata; cur_we = d_we;
      end
      busy = 1'b1;
      k = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    ackp_i = exp_i_ack; ackp_d = exp_d_ack; ackp_l = exp_l_ack;
    if (busy) begin
      k++;
      if (k == 1 && cur_we != 2'b00) mdl_mem[cur_addr] = merge(mdl_mem[cur_addr], cur_wdata, cur_we);
      if (k == 2 + L) begin
        if (cur_own == 2'd1) exp_i_rd = mdl_mem[cur_addr];
        if (cur_own == 2'd2) exp_d_rd = (cur_we == 2'b00) ? mdl_mem[cur_addr] : 64'h0;
      end
      if (k == 3 + L) begin
        busy = 1'b0;
        exp_txn++;
        if (cur_own == 2'd1) rr = 1'b1;
        if (cur_own == 2'd2) rr = 1'b0;
      end
    end
    exp_m_en  = busy && (k == 1);
    exp_owner = busy ? cur_own : 2'd0;
    exp_i_ack = busy && (k == 2 + L) && (cur_own == 2'd1);
    exp_d_ack = busy && (k == 2 + L) && (cur_own == 2'd2);
    exp_l_ack = busy && (k == 2 + L) && (cur_own == 2'd3);
    // memory device: read data valid only L cycles after the strobe
    if (due == cyc) m_rdata = dev_mem[due_addr];
    else m_rdata = {$urandom, $urandom};
    if (m_en) begin
      if (m_we == 2'b00) begin due = cyc + L; due_addr = m_addr; end
      else dev_mem[m_addr] = merge(dev_mem[m_addr], m_wdata, m_we);
    end
    if (ackp_i) i_req = 1'b0;
    if (ackp_d) d_req = 1'b0;
    if (ackp_l) l_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_en", m_en, exp_m_en);
      check("owner", owner, exp_owner);
      check("i_ack", i_ack, exp_i_ack);
      check("d_ack", d_ack, exp_d_ack);
      check("l_ack", l_ack, exp_l_ack);
      check("txn_cnt", txn_cnt, exp_txn);
      check("i_rdata", i_rdata, exp_i_rd);
      check("d_rdata", d_rdata, exp_d_rd);
      if (exp_m_en) begin
        check("m_addr", m_addr, cur_addr);
        check("m_we", m_we, cur_we);
        if (cur_we != 2'b00) check("m_wdata", m_wdata, cur_wdata);
      end
    end
  end

  logic        got_men;
  logic [1:0]  f_we;
  logic [7:0]  f_addr;
  logic [63:0] f_wdata, ack_drd;
  int          n_ack;
  int          ord [8];

  task automatic run_phase(input int n, input int budget);
    got_men = 1'b0;
    n_ack = 0;
    for (int t = 0; t < budget && n_ack < n; t++) begin
      tick();
      if (m_en && !got_men) begin
        got_men = 1'b1; f_we = m_we; f_addr = m_addr; f_wdata = m_wdata;
      end
      if (l_ack && n_ack < 8) begin ord[n_ack] = 3; n_ack++; end
      if (i_ack && n_ack < 8) begin ord[n_ack] = 1; n_ack++; end
      if (d_ack && n_ack < 8) begin ord[n_ack] = 2; n_ack++; ack_drd = d_rdata; end
    end
  endtask

  task automatic d4_read(input logic [63:0] val, output int en_at, output int ack_at, output logic [63:0] rd);
    en_at = -1; ack_at = -1; rd = 64'h0;
    d4_req = 1'b1;
    d4_addr = 8'($urandom);
    for (int t = 1; t <= 12 && ack_at < 0; t++) begin
      @(posedge clk);
      #1;
      if (d4_ack) begin ack_at = t; rd = d4_rdata; d4_req = 1'b0; end
      if (d4_m_en_seen(en_at)) en_at = t;
      m4_rdata = (en_at >= 0 && t == en_at + L4) ? val : {$urandom, $urandom};
    end
    d4_req = 1'b0;
  endtask

  function automatic logic d4_m_en_seen(input int en_at);
    return m4_en && (en_at < 0);
  endfunction

  int          e_at, a_at, cnt;
  logic [63:0] rd4, v;

  initial begin
    reset = 1'b0; reset4 = 1'b0;
    i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
    i_addr = 8'h0; d_addr = 8'h0; l_addr = 8'h0;
    d_wdata = 64'h0; d_we = 2'b00; l_wdata = 32'h0;
    m_rdata = 64'h0; d4_req = 1'b0; d4_addr = 8'h0; m4_rdata = 64'h0;
    for (int a = 0; a < 256; a++) begin
      v = {$urandom, $urandom};
      mdl_mem[a] = v;
      dev_mem[a] = v;
    end
    mdl_mem[4] = 64'h0000_0000_2002_0005;
    dev_mem[4] = 64'h0000_0000_2002_0005;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_owner", owner, 2'd0);
    check("rst_men", m_en, 1'b0);
    check("rst_mwe", m_we, 2'b00);
    check("rst_maddr", m_addr, 8'h0);
    check("rst_mwdata", m_wdata, 64'h0);
    check("rst_txn", txn_cnt, 32'd0);
    check("rst_irdata", i_rdata, 64'h0);
    check("rst_drdata", d_rdata, 64'h0);
    reset = 1'b1; reset4 = 1'b1;
    chk_en = 1'b1;

    // single fetch after reset
    tick();
    check("A_c0_owner", owner, 2'd0);
    i_req = 1'b1; i_addr = 8'h04;
    tick();
    check("A_c1_men", m_en, 1'b1);
    check("A_c1_maddr", m_addr, 8'h04);
    check("A_c1_mwe", m_we, 2'b00);
    tick();
    tick();
    check("A_c3_iack", i_ack, 1'b1);
    check("A_c3_irdata", i_rdata, 64'h0000_0000_2002_0005);
    tick();
    check("A_c4_txn", txn_cnt, 32'd1);

    // 64-bit store
    d_req = 1'b1; d_we = 2'b10; d_addr = 8'd100; d_wdata = 64'd7;
    run_phase(1, 20);
    check("C_mwe", f_we, 2'b10);
    check("C_maddr", f_addr, 8'd100);
    check("C_mwdata", f_wdata, 64'd7);
    check("C_nack", n_ack, 1);
    check("C_owner", ord[0], 2);
    check("C_drdata", ack_drd, 64'h0);
    tick();

    // loader, fetch and load together
    l_req = 1'b1; l_addr = 8'h10; l_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 8'h20;
    d_req = 1'b1; d_addr = 8'h30; d_we = 2'b00;
    run_phase(3, 40);
    check("B_mwe", f_we, 2'b01);
    check("B_maddr", f_addr, 8'h10);
    check("B_mwdata", f_wdata, 64'h0000_0000_DEAD_BEEF);
    check("B_nack", n_ack, 3);
    check("B_ord0", ord[0], 3);
    check("B_ord1", ord[1], 1);
    check("B_ord2", ord[2], 2);
    tick();

    // I and D both held: strict alternation
    i_req = 1'b1; i_addr = 8'h41; d_req = 1'b1; d_addr = 8'h42; d_we = 2'b00;
    n_ack = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (i_ack && n_ack < 8) begin ord[n_ack] = 1; n_ack++; end
      if (d_ack && n_ack < 8) begin ord[n_ack] = 2; n_ack++; end
      if (t < 16) begin
        if (!i_req) begin i_req = 1'b1; i_addr = 8'($urandom); end
        if (!d_req) begin d_req = 1'b1; d_addr = 8'($urandom); end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("RR_nack", n_ack, 4);
    check("RR_ord0", ord[0], 1);
    check("RR_ord1", ord[1], 2);
    check("RR_ord2", ord[2], 1);
    check("RR_ord3", ord[3], 2);

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (busy) begin
        case (cur_own)
          2'd1: i_addr = 8'($urandom);
          2'd2: begin d_addr = 8'($urandom); d_wdata = {$urandom, $urandom}; d_we = 2'($urandom); end
          2'd3: begin l_addr = 8'($urandom); l_wdata = $urandom; end
          default: ;
        endcase
      end
      if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = 8'($urandom); end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = 8'($urandom); d_wdata = {$urandom, $urandom}; d_we = 2'($urandom);
      end
      if (!l_req && $urandom_range(0, 15) == 0) begin
        l_req = 1'b1; l_addr = 8'($urandom); l_wdata = $urandom;
      end
    end
    for (int t = 0; t < 20; t++) tick();
    chk_en = 1'b0;

    // MEM_LAT=4 latency
    d4_read(64'h1111_2222_3333_4444, e_at, a_at, rd4);
    check("L4_men_at", e_at, 1);
    check("L4_ack_at", a_at, 6);
    check("L4_rdata", rd4, 64'h1111_2222_3333_4444);
    @(posedge clk);
    #1;
    check("L4_txn", txn4, 32'd1);

    // reset during WAIT
    d4_req = 1'b1; d4_addr = 8'h33;
    repeat (3) begin @(posedge clk); #1; end
    check("AB_owner_pre", owner4, 2'd2);
    #2 reset4 = 1'b0;
    #1;
    check("AB_owner", owner4, 2'd0);
    check("AB_men", m4_en, 1'b0);
    check("AB_dack", d4_ack, 1'b0);
    check("AB_txn", txn4, 32'd0);
    check("AB_drdata", d4_rdata, 64'h0);
    d4_req = 1'b0;
    @(negedge clk);
    reset4 = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (d4_ack) cnt++;
    end
    check("AB_noack", cnt, 0);
    check("AB_owner_post", owner4, 2'd0);
    d4_read(64'h5555_6666_7777_8888, e_at, a_at, rd4);
    check("AB_re_ack_at", a_at, 6);
    check("AB_re_rdata", rd4, 64'h5555_6666_7777_8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data memory between three requesters: instruction fetch (I), CPU load/store (D) and the UART program loader (L).
- Sits between the MIPS core/loader and the memory macro.
- Serialises accesses through a fixed-latency issue/wait/respond FSM, returning read data with a one-cycle ack pulse per requester.
- Loader has absolute priority; I and D alternate round-robin so neither starves.

Parameters:
- AW, 8, address width in bits
- DW, 64, data width in bits
- MEM_LAT, 1, memory read latency in cycles (m_rdata valid MEM_LAT cycles after m_en); legal range 1..15

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch data, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  load/store request, held until d_ack
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_we  in  2  00 read, 01 32-bit write, 10 or 11 64-bit write
- d_rdata  out  DW  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- l_req  in  1  loader write request, held until l_ack
- l_addr  in  AW  loader address
- l_wdata  in  32  loader word
- l_ack  out  1  one-cycle completion pulse
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  2  write size to memory, encoding as d_we
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data (loader word zero-extended)
- m_rdata  in  DW  memory read data
- owner  out  2  0 none, 1 I, 2 D, 3 L: current transaction owner
- txn_cnt  out  32  completed transactions, wraps at 2^32

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All acks, m_en, m_we, owner and txn_cnt are 0.
  - m_addr, m_wdata, i_rdata and d_rdata are 0.
  - Round-robin pointer rr=0, meaning I is preferred next.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate on this cycle's requests: l_req wins.
  - Otherwise, if exactly one of i_req/d_req is high, grant it.
  - If both are high, grant I when rr=0 and D when rr=1.
  - On a grant, latch owner/address/data/we and go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - m_en=1 for exactly this cycle, with m_addr, m_wdata and m_we driven from the latched values.
  - A loader request uses m_we=01.
  - Load counter to MEM_LAT, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, m_rdata is valid that cycle: register it into the owner's rdata output and go to RESP.
  - Writes take the same path but load 0 into rdata.
- RESP:
  - The owner's ack is 1 for this single cycle.
  - txn_cnt increments.
  - If the owner is I, rr<=1; if D, rr<=0; L leaves rr unchanged.
  - owner<=0 and the FSM goes to IDLE.
- Latency: a request seen in IDLE at cycle c gives m_en at c+1 and ack at c+2+MEM_LAT (MEM_LAT=1: ack at c+3).
- Back-to-back: a requester samples ack, then holds or drops req at the next edge. IDLE always follows RESP, so a stale req is never re-granted. Throughput is one transaction per MEM_LAT+3 cycles.
- Request inputs change only in IDLE sampling. Changes to addr/data after the grant are ignored.
- Non-owner acks stay 0 throughout. i_rdata/d_rdata hold their last value between acks.
- Simultaneous L, I and D requests are served in the order L, then I/D per rr, then the remaining one.
- Reset asserted mid-transaction aborts it immediately and no ack is issued. The requester re-presents after reset.
- txn_cnt wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset release, i_req=1, i_addr=8'h04, m_rdata=64'h0000_0000_2002_0005 (MEM_LAT=1) -> m_en at cycle 1 with m_addr=04, m_we=00; i_ack at cycle 3 with i_rdata=64'h20020005; txn_cnt=1.
- i_req and d_req both held continuously with rr=0 -> grants alternate I, D, I, D; 4 acks in 16 cycles; no two acks in the same cycle.
- l_req, i_req and d_req asserted together, l_addr=8'h10, l_wdata=32'hDEADBEEF -> loader served first: m_we=01, m_wdata=64'h00000000DEADBEEF, l_ack first; then I, then D.
- d_req with d_we=10, d_addr=8'd100, d_wdata=7 -> m_we=10, m_addr=100, m_wdata=7, d_ack with d_rdata=0; i_ack stays 0.
- MEM_LAT=4, single d read -> d_ack exactly 6 cycles after the request is sampled in IDLE.
- reset=0 during WAIT -> outputs clear asynchronously; after release, no ack for the aborted access and owner=0.
